// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision left normalizer: field widths and FSM encoding.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 11;
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/five_decrementor.sv
// 5-bit A-1 built from a ripple chain of half-subtractors; bout is the final borrow.
module five_decrementor (
    input  logic [4:0] a,
    output logic [4:0] y,
    output logic       bout
);

    logic [5:0] borrow;

    always_comb begin
        // NOTE: every always_comb output gets a value before the loop, so no latch is inferred.
        borrow    = 6'b0;
        y         = 5'b0;
        borrow[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            y[i]          = a[i] ^ borrow[i];
            borrow[i + 1] = ~a[i] & borrow[i];
        end
    end

    assign bout = borrow[5];

endmodule

// File: rtl/fp_left_normalizer.sv
// Multi-cycle left normalizer: shifts the significand left one bit per cycle until the
// hidden bit is set, the value is zero, the exponent bottoms out, or the operand is Inf/NaN.
module fp_left_normalizer #(
    parameter int EXP_W = fp16_pkg::EXP_W,
    parameter int MAN_W = fp16_pkg::MAN_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             SignIn,
    input  logic [EXP_W-1:0] ExpIn,
    input  logic [MAN_W-1:0] ManIn,
    output logic             Busy,
    output logic             Done,
    output logic             SignOut,
    output logic [EXP_W-1:0] ExpOut,
    output logic [MAN_W-1:0] ManOut,
    output logic             Zero,
    output logic             Underflow
);

    import fp16_pkg::*;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    norm_state_t      state;
    logic             sign_reg;
    logic [EXP_W-1:0] exp_reg;
    logic [MAN_W-1:0] man_reg;
    logic             zero_reg;
    logic             uf_reg;
    logic             done_reg;
    logic [EXP_W-1:0] exp_dec;
    logic             dec_borrow;

    generate
        if (EXP_W == 5) begin : g_dec5
            five_decrementor u_dec (
                .a    (exp_reg),
                .y    (exp_dec),
                .bout (dec_borrow)
            );
        end else begin : g_dec_generic
            assign exp_dec    = exp_reg - {{(EXP_W-1){1'b0}}, 1'b1};
            assign dec_borrow = (exp_reg == '0);
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            sign_reg <= 1'b0;
            exp_reg  <= '0;
            man_reg  <= '0;
            zero_reg <= 1'b0;
            uf_reg   <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every rule sees the pre-edge values.
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        sign_reg <= SignIn;
                        exp_reg  <= ExpIn;
                        man_reg  <= ManIn;
                        zero_reg <= 1'b0;
                        uf_reg   <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Rule order matters: Inf/NaN beats normalized beats zero beats underflow.
                    if (exp_reg == EXP_ONES) begin
                        state <= DONE;
                    end else if (man_reg[MAN_W-1]) begin
                        state <= DONE;
                    end else if (man_reg == '0) begin
                        exp_reg  <= '0;
                        zero_reg <= 1'b1;
                        state    <= DONE;
                    end else if (exp_reg == '0) begin
                        uf_reg <= 1'b1;
                        state  <= DONE;
                    end else begin
                        // Exponent is non-zero here, so the decrement can never borrow out.
                        assert (!dec_borrow);
                        man_reg <= {man_reg[MAN_W-2:0], 1'b0};
                        exp_reg <= exp_dec;
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state != IDLE);
    assign Done      = done_reg;
    assign SignOut   = sign_reg;
    assign ExpOut    = exp_reg;
    assign ManOut    = man_reg;
    assign Zero      = zero_reg;
    assign Underflow = uf_reg;

endmodule
